// File: rtl/pe_inject_arbiter.sv
// pe_inject_arbiter
// Round-robin arbiter that shares one router injection port of a PE among
// N_REQ packet sources (activation broadcast, completion/status, debug).
// A winning source keeps the port until its last flit is accepted, so
// multi-flit bursts are never interleaved. The arbiter owns the single
// output register that drives send_en/send_addr/send_data into the router.
//
// Timing:
//   - A flit accepted in cycle t is presented on send_* in cycle t+1.
//   - The output slot can be drained and reloaded in the same cycle, so
//     back-to-back flits stream at one per cycle while router_rdy is high.

module pe_inject_arbiter #(
  parameter int N_REQ  = 3,   // number of requesters (2..8)
  parameter int ADDR_W = 6,   // router destination address width
  parameter int DATA_W = 16   // flit payload width
) (
  input  logic                      clk,
  input  logic                      rst,         // synchronous, active-low
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      router_rdy,
  output logic                      send_en,
  output logic [ADDR_W-1:0]         send_addr,
  output logic [DATA_W-1:0]         send_data,
  output logic                      busy
);

  // --------------------------------------------------------------------------
  // Types and helpers
  // --------------------------------------------------------------------------
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // IDLE: round-robin among all sources. LOCKED: port reserved for owner_q.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Successor of a source index, wrapping at N_REQ (N_REQ need not be 2^k).
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(N_REQ - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  ptr_t                rr_ptr_q, rr_ptr_d;   // first source searched in IDLE
  ptr_t                owner_q, owner_d;     // burst owner while LOCKED

  logic                send_en_q, send_en_d;
  logic [ADDR_W-1:0]   send_addr_q, send_addr_d;
  logic [DATA_W-1:0]   send_data_q, send_data_d;

  logic                slot_free;            // output register can take a flit
  logic                rr_found;             // some source is valid (IDLE search)
  ptr_t                rr_pick;              // round-robin winner
  ptr_t                scan;                 // search cursor
  ptr_t                grant_idx;            // source granted this cycle
  logic                grant_ok;             // granted source is presenting a flit
  logic                accept;               // a flit is taken this cycle
  logic                accept_last;          // ...and it closes its packet

  // The slot is free if it is empty or its flit is leaving this cycle.
  assign slot_free = ~send_en_q | router_rdy;

  // --------------------------------------------------------------------------
  // Round-robin search: first valid source at or after rr_ptr_q, wrapping.
  // --------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = rr_ptr_q;
    scan     = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!rr_found && req_valid[scan]) begin
        rr_found = 1'b1;
        rr_pick  = scan;
      end
      scan = next_ptr(scan);
    end
  end

  // --------------------------------------------------------------------------
  // FSM (1/3): state register with synchronous active-low reset.
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, regardless of order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM (2/3): next state, round-robin pointer and burst owner.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (accept) begin
      if (accept_last) begin
        // Packet complete: release the port and rotate past the sender.
        state_d  = ST_IDLE;
        rr_ptr_d = next_ptr(grant_idx);
      end else begin
        // Burst continues: reserve the port for this source. In LOCKED the
        // grant is always the owner, so owner_d is unchanged there.
        state_d  = ST_LOCKED;
        owner_d  = grant_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM (3/3): grant decode, one-hot ready and busy.
  // --------------------------------------------------------------------------
  always_comb begin
    if (state_q == ST_LOCKED) begin
      // Only the owner may be served; an idle owner still blocks everyone.
      grant_idx = owner_q;
      grant_ok  = req_valid[owner_q];
    end else begin
      grant_idx = rr_pick;
      grant_ok  = rr_found;
    end
    // Reset masks the grant combinationally so nothing is taken while rst==0.
    accept      = rst & slot_free & grant_ok;
    accept_last = req_last[grant_idx];
    req_ready   = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
    busy = send_en_q | (state_q == ST_LOCKED);
  end

  // --------------------------------------------------------------------------
  // Output slot next state: load on accept, clear on drain, else hold.
  // --------------------------------------------------------------------------
  always_comb begin
    send_en_d   = send_en_q;
    send_addr_d = send_addr_q;
    send_data_d = send_data_q;
    if (accept) begin
      // Covers drain-and-reload in the same cycle: send_en stays high.
      send_en_d   = 1'b1;
      send_addr_d = req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
      send_data_d = req_data[int'(grant_idx) * DATA_W +: DATA_W];
    end else if (router_rdy) begin
      // Flit left (or slot was already empty); payload bits are don't-care.
      send_en_d   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output slot register; reset drops any pending flit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      send_en_q   <= 1'b0;
      send_addr_q <= '0;
      send_data_q <= '0;
    end else begin
      send_en_q   <= send_en_d;
      send_addr_q <= send_addr_d;
      send_data_q <= send_data_d;
    end
  end

  assign send_en   = send_en_q;
  assign send_addr = send_addr_q;
  assign send_data = send_data_q;

  // --------------------------------------------------------------------------
  // Embedded protocol checks
  // --------------------------------------------------------------------------
  // At most one source is granted in any cycle.
  a_ready_onehot : assert property (@(posedge clk) $onehot0(req_ready));

  // A stalled output flit is held unchanged until the router takes it.
  a_stall_hold : assert property (@(posedge clk) disable iff (!rst)
    (send_en_q && !router_rdy) |=>
      (send_en_q && $stable(send_addr_q) && $stable(send_data_q)));

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// tb_pe_inject_arbiter
// Scoreboard bench for pe_inject_arbiter (N_REQ=3, ADDR_W=6, DATA_W=16).
// Per-source flit queues feed the DUT; a reference arbiter model predicts
// req_ready every cycle and pushes each accepted flit to an expected queue
// that is popped and compared as the flit leaves on send_*. Inputs change
// 1 time unit after posedge; outputs are sampled on negedge.

module tb_pe_inject_arbiter;

  localparam int N  = 3;
  localparam int AW = 6;
  localparam int DW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } flit_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            router_rdy;
  logic            send_en;
  logic [AW-1:0]   send_addr;
  logic [DW-1:0]   send_data;
  logic            busy;

  pe_inject_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .router_rdy (router_rdy),
    .send_en    (send_en),
    .send_addr  (send_addr),
    .send_data  (send_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Stimulus sources, scoreboard and reference-model state.
  flit_t src_q [N][$];
  flit_t exp_q [$];
  bit    pause [N];
  logic  rst_v;
  logic  rdy_v;
  int    acc_idx  = -1;
  bit    m_locked = 1'b0;
  int    m_owner  = 0;
  int    m_ptr    = 0;
  int    log_code = 0;   // grant order, one decimal digit (source+1) per grant
  int    total    = 0;
  int    bad      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit src_valid(input int s);
    return (src_q[s].size() != 0) && !pause[s];
  endfunction

  task automatic push_flit(input int s, input int addr, input int data, input bit last);
    flit_t f;
    f.addr = addr[AW-1:0];
    f.data = data[DW-1:0];
    f.last = last;
    src_q[s].push_back(f);
  endtask

  // Apply next-cycle inputs just after the clock edge.
  task automatic drive();
    flit_t f;
    rst        = rst_v;
    router_rdy = rdy_v;
    if (acc_idx >= 0) f = src_q[acc_idx].pop_front();
    acc_idx = -1;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) begin
        f = src_q[i][0];
        req_addr[i*AW +: AW] = f.addr;
        req_data[i*DW +: DW] = f.data;
        req_last[i]          = f.last;
        req_valid[i]         = !pause[i];
      end else begin
        req_addr[i*AW +: AW] = '0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
        req_valid[i]         = 1'b0;
      end
    end
  endtask

  // Compare outputs against the model, then advance the model one cycle.
  task automatic monitor();
    bit           occ;
    int           g;
    logic [N-1:0] exp_rdy;
    flit_t        f;
    occ = (exp_q.size() != 0);
    check("send_en", send_en, occ);
    check("busy", busy, occ | m_locked);
    if (occ) begin
      check("send_addr", send_addr, exp_q[0].addr);
      check("send_data", send_data, exp_q[0].data);
      if (router_rdy) f = exp_q.pop_front();
    end
    g = -1;
    if (m_locked) begin
      if (src_valid(m_owner)) g = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && src_valid((m_ptr + k) % N)) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (rst && (!occ || router_rdy) && g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (exp_rdy != '0) begin
      f = src_q[g][0];
      exp_q.push_back(f);
      acc_idx  = g;
      log_code = log_code * 10 + g + 1;
      if (f.last) begin
        m_locked = 1'b0;
        m_ptr    = (g + 1) % N;
      end else begin
        m_locked = 1'b1;
        m_owner  = g;
      end
    end
    if (!rst) begin
      exp_q.delete();
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
      acc_idx  = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  function automatic int pending();
    int n = exp_q.size() + (m_locked ? 1 : 0);
    for (int i = 0; i < N; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic run_until_idle(input string tag);
    int n = 0;
    while (pending() != 0 && n < 60) begin
      step();
      n++;
    end
    check({tag, "_drained"}, pending(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    router_rdy = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_addr   = '0;
    req_data   = '0;
    rst_v      = 1'b0;
    rdy_v      = 1'b1;
    for (int i = 0; i < N; i++) pause[i] = 1'b0;

    // Reset held 3 cycles with every source valid, then fairness 0,1,2,0,1,2.
    for (int s = 0; s < N; s++) begin
      push_flit(s, 10 + s, 16'h0100 * s + 1, 1'b1);
      push_flit(s, 10 + s, 16'h0100 * s + 2, 1'b1);
    end
    repeat (3) step();
    check("rst_ready", req_ready, 3'b000);
    check("rst_send_en", send_en, 1'b0);
    rst_v    = 1'b1;
    log_code = 0;
    repeat (6) step();
    check("fair_order", log_code, 123123);
    run_until_idle("fair");

    // Backpressure: flit A stalls 4 cycles, then drains while B loads.
    rdy_v = 1'b0;
    push_flit(0, 5, 16'h1234, 1'b1);
    push_flit(1, 9, 16'hABCD, 1'b1);
    step();
    repeat (4) begin
      step();
      check("bp_addr", send_addr, 6'd5);
      check("bp_data", send_data, 16'h1234);
      check("bp_ready", req_ready, 3'b000);
    end
    rdy_v = 1'b1;
    step();
    check("bp_reload", req_ready, 3'b010);
    step();
    check("bp_no_bubble", send_en, 1'b1);
    check("bp_b_data", send_data, 16'hABCD);
    run_until_idle("bp");

    // Burst lock: bring rr_ptr to 1, then 3-flit burst from source 1 with
    // source 0 waiting; a trailing single from 1 shows rr_ptr moved to 2.
    push_flit(0, 7, 16'h0777, 1'b1);
    run_until_idle("pre_burst");
    log_code = 0;
    push_flit(1, 20, 16'h1001, 1'b0);
    push_flit(1, 20, 16'h1002, 1'b0);
    push_flit(1, 20, 16'h1003, 1'b1);
    push_flit(1, 21, 16'h1004, 1'b1);
    push_flit(0, 22, 16'h2001, 1'b1);
    run_until_idle("burst");
    check("burst_order", log_code, 22212);

    // Locked idle: owner 2 pauses mid-burst while 0 and 1 are valid.
    log_code = 0;
    push_flit(2, 30, 16'h3001, 1'b0);
    push_flit(2, 30, 16'h3002, 1'b0);
    push_flit(2, 30, 16'h3003, 1'b1);
    push_flit(0, 31, 16'h3100, 1'b1);
    push_flit(1, 32, 16'h3200, 1'b1);
    step();
    pause[2] = 1'b1;
    repeat (2) begin
      step();
      check("lock_ready", req_ready, 3'b000);
      check("lock_busy", busy, 1'b1);
    end
    pause[2] = 1'b0;
    run_until_idle("lock");
    check("lock_order", log_code, 33312);

    // Reset mid-burst: source 1 locked with a flit pending on send_*.
    push_flit(1, 40, 16'h5001, 1'b0);
    push_flit(1, 40, 16'h5002, 1'b0);
    push_flit(1, 40, 16'h5003, 1'b1);
    step();
    step();
    check("rb_busy", busy, 1'b1);
    check("rb_send_en", send_en, 1'b1);
    rst_v = 1'b0;
    step();
    check("rb_rst_ready", req_ready, 3'b000);
    for (int i = 0; i < N; i++) src_q[i].delete();
    rst_v = 1'b1;
    push_flit(0, 41, 16'h6000, 1'b1);
    push_flit(1, 42, 16'h6100, 1'b1);
    step();
    check("rb_send_en_clr", send_en, 1'b0);
    check("rb_busy_clr", busy, 1'b0);
    check("rb_first", req_ready, 3'b001);
    run_until_idle("rb");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
